// File: rtl/byte_pair_arbiter.sv
// Round-robin arbiter sharing one 8->16 byte-pair packer among N_REQ byte streams.
// Optional second-byte timeout with zero padding is enabled by defining PAIR_TIMEOUT_EN.
module byte_pair_arbiter #(
    parameter int  N_REQ   = 4,
    parameter int  TIMEOUT = 16,
    localparam int SRC_W   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 out_valid,
    output logic [15:0]          out_data,
    output logic [SRC_W-1:0]     out_src,
    input  logic                 out_ready,
    output logic                 out_pad,
    output logic                 busy
);

    if (N_REQ < 2 || TIMEOUT < 1) begin : g_param_chk
        $error("byte_pair_arbiter: N_REQ must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t             state_q;
    logic [SRC_W-1:0]   grant_q;
    logic [SRC_W-1:0]   last_grant_q;
    logic [N_REQ-1:0]   req_ready_q;
    logic               out_valid_q;
    logic [15:0]        out_data_q;
    logic [SRC_W-1:0]   out_src_q;
    logic               busy_q;

    logic [SRC_W-1:0]   pick_d;
    logic [SRC_W-1:0]   cand;
    logic               found;
    logic               xfer;
    logic [7:0]         gnt_byte;
    logic [7:0]         req_byte [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_byte
        assign req_byte[i] = req_data[8*i +: 8];
    end

    function automatic logic [N_REQ-1:0] onehot(input logic [SRC_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Search starts one past the last completed grant, wrapping mod N_REQ.
    always_comb begin
        pick_d = last_grant_q;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = SRC_W'((int'(last_grant_q) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                pick_d = cand;
                found  = 1'b1;
            end
        end
    end

    // req_ready_q is only ever one-hot(grant_q) or zero, so this is the granted byte transfer.
    assign xfer     = |(req_valid & req_ready_q);
    assign gnt_byte = req_byte[grant_q];

`ifdef PAIR_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             out_pad_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_W'(N_REQ - 1);
            req_ready_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            busy_q       <= 1'b0;
`ifdef PAIR_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            out_pad_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        grant_q     <= pick_d;
                        req_ready_q <= onehot(pick_d);
                        busy_q      <= 1'b1;
                        state_q     <= FIRST;
                    end
                end
                FIRST: begin
                    if (xfer) begin
                        out_data_q[15:8] <= gnt_byte;
                        state_q          <= SECOND;
`ifdef PAIR_TIMEOUT_EN
                        tmo_cnt_q        <= '0;
`endif
                    end
                end
                SECOND: begin
                    if (xfer) begin
                        out_data_q[7:0] <= gnt_byte;
                        out_src_q       <= grant_q;
                        out_valid_q     <= 1'b1;
                        req_ready_q     <= '0;
                        state_q         <= HOLD;
`ifdef PAIR_TIMEOUT_EN
                    end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // A late byte in the expiry cycle takes the branch above instead.
                        out_data_q[7:0] <= 8'h00;
                        out_src_q       <= grant_q;
                        out_valid_q     <= 1'b1;
                        out_pad_q       <= 1'b1;
                        req_ready_q     <= '0;
                        state_q         <= HOLD;
                    end else begin
                        tmo_cnt_q       <= tmo_cnt_q + 1'b1;
`endif
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q  <= 1'b0;
                        last_grant_q <= grant_q;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
`ifdef PAIR_TIMEOUT_EN
                        out_pad_q    <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign busy      = busy_q;
`ifdef PAIR_TIMEOUT_EN
    assign out_pad   = out_pad_q;
`else
    assign out_pad   = 1'b0;
`endif

endmodule
